// File: rtl/mul_div_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The pipeline drives the master side and the unit implements the slave side.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_div;
  logic             is_signed;
  logic             cancel;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_div, is_signed, cancel, src1, src2,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, is_div, is_signed, cancel, src1, src2,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider that share one WIDTH-cycle engine.
// Operands are iterated as magnitudes; signs are applied once in FIX.
module mul_div_unit #(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          resetn,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   op;
  logic               div_q;
  logic               neg_res;
  logic               neg_rem;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dz_flag;

  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start && !bus.cancel) state_next = CALC;
      CALC:    if (bus.cancel) state_next = IDLE;
               else if (cnt == CNT_W'(1)) state_next = FIX;
      FIX:     state_next = bus.cancel ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Magnitudes; the most negative value maps to itself, which reads correctly as unsigned.
  always_comb begin
    abs1 = (bus.is_signed && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
    abs2 = (bus.is_signed && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, op};
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, op}) : div_shift[WIDTH-1:0];
    step_next = div_q ? {div_rem, acc[WIDTH-2:0], div_ge}
                      : {mul_sum, acc[WIDTH-1:1]};
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      op      <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_flag <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (bus.start && !bus.cancel) begin
          div_q   <= bus.is_div;
          neg_res <= bus.is_signed & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
          neg_rem <= bus.is_signed & bus.src1[WIDTH-1];
          dz_q    <= bus.is_div && (bus.src2 == '0);
          cnt     <= CNT_W'(WIDTH);
          acc     <= {{WIDTH{1'b0}}, (bus.is_div ? abs1 : abs2)};
          op      <= bus.is_div ? abs2 : abs1;
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt - CNT_W'(1);
        end
        // With a zero divisor the remainder equals |dividend|, so rem_fix restores src1.
        FIX: if (!bus.cancel) begin
          hi_q    <= div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_q    <= div_q ? (dz_q ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
          dz_flag <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == CALC) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dz_flag;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, signed/unsigned results,
// divide-by-zero, cancel, ignored start while busy and asynchronous reset.
module tb_mul_div_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   passed = 0;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issues one operation and checks latency, busy window, results and the single done pulse.
  task automatic run_op(input string tag, input logic div, input logic sgn,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo,
                        input logic exp_dz, input bit glitch);
    int n;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.is_div = div; bus.is_signed = sgn; bus.src1 = a; bus.src2 = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (glitch && n == 5) begin
        bus.start = 1'b1; bus.is_div = ~div; bus.src1 = '1; bus.src2 = 3;
      end else if (glitch && n == 6) begin
        bus.start = 1'b0; bus.is_div = div; bus.src1 = a; bus.src2 = b;
      end
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(WIDTH + 2));
    check({tag, " busy window"}, 64'(busy_ok), 64'd1);
    check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dz));
    @(negedge clk);
    check({tag, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    bit done_seen;
    bus.start = 1'b0; bus.is_div = 1'b0; bus.is_signed = 1'b0; bus.cancel = 1'b0;
    bus.src1 = '0; bus.src2 = '0;
    #12;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset dz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("mulu 7x6",     1'b0, 1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0, 1'b0);
    run_op("mulu ffxff",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("mul -1x-1",    1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000001, 1'b0, 1'b0);
    run_op("mul -3x5",     1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    run_op("div -7/2",     1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu 100/7",   1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0);
    run_op("divu 100/0",   1'b1, 1'b0, 32'd100,      32'd0,        32'h64,       32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("div min/-1",   1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b0);
    run_op("div -5/0",     1'b1, 1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("mulu 3x3",     1'b0, 1'b0, 32'd3,        32'd3,        32'h0,        32'd9,        1'b0, 1'b0);

    // Cancel during cycle 10 of a multiply; previous result (0:9) must survive.
    @(negedge clk);
    bus.start = 1'b1; bus.is_div = 1'b0; bus.is_signed = 1'b0;
    bus.src1 = 32'h12345678; bus.src2 = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c < 11; c++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      if (c == 10) bus.cancel = 1'b1;
      @(negedge clk);
    end
    bus.cancel = 1'b0;
    check("cancel no done", 64'(done_seen | bus.done), 64'd0);
    check("cancel idle", 64'(bus.busy), 64'd0);
    check("cancel hi kept", 64'(bus.hi), 64'd0);
    check("cancel lo kept", 64'(bus.lo), 64'd9);
    run_op("retry", 1'b0, 1'b0, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, 1'b0);

    // Cancel together with start in IDLE: start is dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("cancel beats start", 64'(bus.busy), 64'd0);

    run_op("start ignored", 1'b0, 1'b0, 32'd1000, 32'd1000, 32'h0, 32'h000F4240, 1'b0, 1'b1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.start = 1'b1; bus.is_div = 1'b0; bus.is_signed = 1'b0; bus.src1 = 32'd9; bus.src2 = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("areset busy", 64'(bus.busy), 64'd0);
    check("areset done", 64'(bus.done), 64'd0);
    check("areset hi", 64'(bus.hi), 64'd0);
    check("areset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("post reset 7x6", 1'b0, 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit for the EXE stage of the 5-stage pipeline. It replaces single-cycle combinational multiply/divide with a shift-add multiplier and a restoring divider. It shares one WIDTH-cycle iteration engine and produces HI/LO results. EXE_over is gated by its done pulse. It supports signed/unsigned operation, divide-by-zero flagging and pipeline cancel (exception/eret flush).

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request pulse, sampled only in IDLE
is_div  in  1  1 = divide, 0 = multiply
is_signed  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU)
src1  in  WIDTH  multiplicand / dividend
src2  in  WIDTH  multiplier / divisor
cancel  in  1  flush; aborts any operation in progress
busy  out  1  high from the cycle after start is accepted until done is asserted (inclusive of the FIX state)
done  out  1  single-cycle pulse; hi/lo valid in that cycle
hi  out  WIDTH  product[2*WIDTH-1:WIDTH] or remainder
lo  out  WIDTH  product[WIDTH-1:0] or quotient
div_by_zero  out  1  registered flag, set with done when is_div and src2==0

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; busy, done, div_by_zero = 0; hi, lo = 0; counter = 0.
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: when start=1 and cancel=0, latch is_div and is_signed. Latch |src1| and |src2| (absolute values only when is_signed; |−2^(WIDTH−1)| = 2^(WIDTH−1) as unsigned). Latch the sign bits. Load counter=WIDTH, go to CALC.
  - CALC: one iteration per cycle; decrement counter; go to FIX when counter reaches 1 on this cycle, i.e. exactly WIDTH CALC cycles.
    - Multiply: 2*WIDTH accumulator, shift-add on LSB of multiplier.
    - Divide: restoring, one quotient bit per cycle, MSB first, remainder register WIDTH+1 bits.
  - FIX: apply sign correction, write hi/lo registers, go to DONE.
  - DONE: done=1 for one cycle, div_by_zero valid; return to IDLE.
- Latency: start sampled at edge N -> done high in cycle N+WIDTH+2 (34 cycles for WIDTH=32). Back-to-back: new start accepted no earlier than the cycle after done.
- Sign rules (is_signed=1):
  - product negated (2*WIDTH two's complement) if sign1^sign2.
  - quotient negated if sign1^sign2.
  - remainder takes the sign of the dividend.
  - −2^(WIDTH−1) / −1 -> lo = 2^(WIDTH−1) (bit pattern 0x80000000), hi = 0, no flag.
- Divide by zero (either signedness): quotient iteration runs normally; lo = all ones, hi = src1 as latched (original signed value), div_by_zero=1. Same latency.
- Multiply: div_by_zero always 0.
- hi/lo hold their last values until the next FIX; they are never cleared except by reset.
- start while not IDLE: ignored, no queueing.
- cancel:
  - Any state except IDLE -> IDLE next edge; done not asserted; hi/lo/div_by_zero unchanged.
  - cancel with start in IDLE: cancel wins, start ignored.
  - cancel in DONE: done still asserted that cycle (result already committed), then IDLE.
- Reset mid-operation: immediate return to reset values; no done pulse.
- EXE integration: EXE_over = EXE_valid & (~(multiply|divide) | done); hi_write/lo_write qualified by done.

Test Plan:
1. Unsigned mult 7 × 6, start at cycle 0 -> busy cycles 1–33, done at cycle 34, hi=0x00000000, lo=0x0000002A, div_by_zero=0.
2. Unsigned mult 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands signed (−1 × −1) -> hi=0x00000000, lo=0x00000001.
3. Signed mult −3 × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed div −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned div 100 / 7 -> lo=14, hi=2.
4. Divide by zero: 100 / 0 unsigned -> done at cycle 34, lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1. Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
5. cancel at cycle 10 of a multiply -> no done; IDLE at cycle 11; hi/lo keep the previous result. Retry start at cycle 12 -> done at cycle 46. start pulsed while busy -> ignored.
6. resetn asserted asynchronously mid-CALC -> busy/done/hi/lo = 0 immediately; start after release behaves as in scenario 1.
